id_hazard_ctrl: RTL and testbench

Hazard and pipeline-control unit that drives the stall/flush inputs of the IF/ID and ID/EX pipeline registers. It is the initiator side of the stall/flush interface that the decode stage responds to.
- Consumes decoded source operands of the instruction in ID, plus EX/MA destination and control fields.
- Detects load-use hazards, multi-cycle EX occupancy and branch mispredicts.
- Sequences bubbles, holds and flushes with a small FSM and counter.

---
 rtl/id_hazard_ctrl.sv | 159 +++++++++++++++
 tb/tb_id_hazard_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/id_hazard_ctrl.sv
//------------------------------------------------------------------------------
// id_hazard_ctrl : load-use / multi-cycle / mispredict stall-flush sequencer
// Optional macro HAZARD_PERF_EN adds saturating stall/flush performance counters.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module id_hazard_ctrl #(
    parameter int LOAD_LATENCY = 1,
    parameter bit REG0_ZERO    = 1'b1
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic        ex_valid,
    input  logic [4:0]  ex_rds,
    input  logic        ex_mem_read,
    input  logic        ex_mispredict,
    input  logic        ex_mc_start,
    input  logic        ex_mc_done,
    output logic        pc_stall,
    output logic        ifid_stall,
    output logic        ifid_flush,
    output logic        idex_stall,
    output logic        idex_flush,
    output logic [1:0]  hz_state,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MC_WAIT  = 2'd2,
        UNUSED   = 2'd3
    } state_e;

    localparam logic [2:0] LU_RELOAD = 3'(LOAD_LATENCY - 1);

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       w_lu_hit, w_mp, w_rd_ok;
    logic       w_front_stall, w_ifid_flush, w_idex_stall, w_idex_flush;

    assign w_rd_ok  = REG0_ZERO ? (ex_rds != 5'd0) : 1'b1;
    assign w_lu_hit = ex_valid & ex_mem_read & id_valid & w_rd_ok &
                      ((id_uses_rs1 & (id_rs1 == ex_rds)) |
                       (id_uses_rs2 & (id_rs2 == ex_rds)));
    assign w_mp     = ex_valid & ex_mispredict;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        w_front_stall = 1'b0;
        w_ifid_flush  = 1'b0;
        w_idex_stall  = 1'b0;
        w_idex_flush  = 1'b0;
        case (state_q)
            RUN: begin
                if (w_mp) begin
                    w_ifid_flush = 1'b1;
                    w_idex_flush = 1'b1;
                    cnt_d        = 3'd0;
                end else if (ex_mc_start) begin
                    w_front_stall = 1'b1;
                    w_idex_stall  = 1'b1;
                    state_d       = MC_WAIT;
                end else if (w_lu_hit) begin
                    w_front_stall = 1'b1;
                    w_idex_flush  = 1'b1;
                    if (LOAD_LATENCY > 1) begin
                        state_d = LU_STALL;
                        cnt_d   = LU_RELOAD;
                    end
                end
            end
            LU_STALL: begin
                if (w_mp) begin
                    w_ifid_flush = 1'b1;
                    w_idex_flush = 1'b1;
                    cnt_d        = 3'd0;
                    state_d      = RUN;
                end else if (ex_mc_start) begin
                    w_front_stall = 1'b1;
                    w_idex_stall  = 1'b1;
                    cnt_d         = 3'd0;
                    state_d       = MC_WAIT;
                end else begin
                    // Load-use is not re-checked here: the bubble count was fixed on entry.
                    w_front_stall = 1'b1;
                    w_idex_flush  = 1'b1;
                    cnt_d         = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        state_d = RUN;
                    end
                end
            end
            MC_WAIT: begin
                w_front_stall = 1'b1;
                w_idex_stall  = 1'b1;
                if (ex_mc_done) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc_stall   = ~reset & w_front_stall;
    assign ifid_stall = ~reset & w_front_stall;
    assign ifid_flush = ~reset & w_ifid_flush;
    assign idex_stall = ~reset & w_idex_stall;
    assign idex_flush = ~reset & w_idex_flush;
    assign hz_state   = state_q;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge Clk) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (pc_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (ifid_flush && (flush_cnt_q != 32'hFFFF_FFFF)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_events = flush_cnt_q;
`else
    assign stall_cycles = 32'd0;
    assign flush_events = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_id_hazard_ctrl.sv
//------------------------------------------------------------------------------
// tb_id_hazard_ctrl : directed + random scoreboard bench for id_hazard_ctrl
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_id_hazard_ctrl;

    localparam int C_LL   = 3;
    localparam bit C_REG0 = 1'b1;

    logic        Clk = 1'b0;
    logic        reset;
    logic        id_valid, id_uses_rs1, id_uses_rs2;
    logic [4:0]  id_rs1, id_rs2, ex_rds;
    logic        ex_valid, ex_mem_read, ex_mispredict, ex_mc_start, ex_mc_done;
    logic        pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
    logic [1:0]  hz_state;
    logic [31:0] stall_cycles, flush_events;

    id_hazard_ctrl #(.LOAD_LATENCY(C_LL), .REG0_ZERO(C_REG0)) dut (
        .Clk(Clk), .reset(reset),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_valid(ex_valid), .ex_rds(ex_rds), .ex_mem_read(ex_mem_read),
        .ex_mispredict(ex_mispredict), .ex_mc_start(ex_mc_start), .ex_mc_done(ex_mc_done),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
        .idex_stall(idex_stall), .idex_flush(idex_flush), .hz_state(hz_state),
        .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [4:0]  ctl;   // {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush}
        logic [1:0]  hz;
        logic [31:0] sc;
        logic [31:0] fe;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: remaining load-use bubbles, multi-cycle busy flag, perf totals
    int          m_bubbles = 0;
    bit          m_mc      = 1'b0;
    logic [31:0] m_sc      = 32'd0;
    logic [31:0] m_fe      = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(negedge Clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("ctl", {27'd0, pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush},
                  {27'd0, e.ctl});
            check("hz_state", {30'd0, hz_state}, {30'd0, e.hz});
            check("stall_cycles", stall_cycles, e.sc);
            check("flush_events", flush_events, e.fe);
        end
    end

    function automatic bit lu_now();
        bit match;
        match = (id_uses_rs1 && id_rs1 == ex_rds) || (id_uses_rs2 && id_rs2 == ex_rds);
        return ex_valid && ex_mem_read && id_valid && match && !(C_REG0 && ex_rds == 5'd0);
    endfunction

    // Predict this cycle's response from the current inputs, then advance the model.
    task automatic step();
        exp_t e;
        bit   stall_all, bubble, flush;
        stall_all = 0; bubble = 0; flush = 0;
        e.hz = m_mc ? 2'd2 : (m_bubbles > 0 ? 2'd1 : 2'd0);
`ifdef HAZARD_PERF_EN
        e.sc = m_sc;
        e.fe = m_fe;
`else
        e.sc = 32'd0;
        e.fe = 32'd0;
`endif
        if (reset) begin
            m_bubbles = 0;
            m_mc      = 0;
            m_sc      = 32'd0;
            m_fe      = 32'd0;
        end else if (m_mc) begin
            stall_all = 1;
            if (ex_mc_done) m_mc = 0;
        end else if (ex_valid && ex_mispredict) begin
            flush     = 1;
            m_bubbles = 0;
        end else if (ex_mc_start) begin
            stall_all = 1;
            m_mc      = 1;
            m_bubbles = 0;
        end else if (m_bubbles > 0) begin
            bubble    = 1;
            m_bubbles = m_bubbles - 1;
        end else if (lu_now()) begin
            bubble    = 1;
            m_bubbles = C_LL - 1;
        end
        e.ctl = {stall_all | bubble, stall_all | bubble, flush, stall_all, bubble | flush};
        if (!reset) begin
            if ((stall_all || bubble) && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
            if (flush && m_fe != 32'hFFFF_FFFF) m_fe = m_fe + 1;
        end
        exp_q.push_back(e);
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 0; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        ex_valid = 0; ex_rds = 0; ex_mem_read = 0; ex_mispredict = 0;
        ex_mc_start = 0; ex_mc_done = 0;
    endtask

    task automatic set_lu(input logic [4:0] rd);
        ex_valid = 1; ex_mem_read = 1; ex_rds = rd;
        id_valid = 1; id_uses_rs1 = 1; id_rs1 = rd;
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        repeat (2) @(posedge Clk);
        #1;
        step();                                   // reset held: outputs 0
        reset = 0;

        set_lu(5'd5); step();                     // load-use: 3 stall/bubble cycles
        idle_inputs(); repeat (3) step();

        set_lu(5'd0); step();                     // x0 never hazards
        idle_inputs(); step();

        set_lu(5'd7); step();                     // mispredict in 2nd stall cycle
        idle_inputs(); ex_valid = 1; ex_mispredict = 1; step();
        idle_inputs(); repeat (2) step();

        ex_mc_start = 1; step();                  // multi-cycle with ignored mispredict
        idle_inputs(); ex_valid = 1; ex_mispredict = 1; repeat (3) step();
        idle_inputs(); ex_mc_done = 1; step();
        idle_inputs(); repeat (2) step();

        ex_mc_start = 1; set_lu(5'd3); step();    // mc_start beats lu_hit
        idle_inputs(); step();
        reset = 1; step();                        // reset mid-wait
        idle_inputs(); repeat (2) step();

        for (int i = 0; i < 600; i++) begin
            bit idle_now;
            idle_now      = (m_bubbles == 0) && !m_mc;
            reset         = ($urandom_range(0, 59) == 0);
            id_valid      = ($urandom_range(0, 3) != 0);
            id_rs1        = 5'($urandom_range(0, 3));
            id_rs2        = 5'($urandom_range(0, 3));
            id_uses_rs1   = $urandom_range(0, 1);
            id_uses_rs2   = $urandom_range(0, 1);
            ex_valid      = ($urandom_range(0, 3) != 0);
            ex_rds        = 5'($urandom_range(0, 3));
            ex_mem_read   = $urandom_range(0, 1);
            ex_mispredict = ($urandom_range(0, 7) == 0);
            ex_mc_start   = idle_now && ($urandom_range(0, 9) == 0);
            ex_mc_done    = m_mc && ($urandom_range(0, 3) == 0);
            step();
        end

        idle_inputs();
        step();
        @(negedge Clk);
        #1;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
